// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, LSB first, one full adder,
// IDLE -> RUN (WIDTH edges) -> DONE (one-cycle done pulse) -> IDLE.

module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum,
  output logic carry
);

  assign sum   = a_in ^ b_in ^ c_in;
  assign carry = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_cat;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             fa_s;
  logic             fa_c;
  logic             last;
  logic             accept;

  full_adder u_fa (
    .a_in  (a_sr[0]),
    .b_in  (b_sr[0]),
    .c_in  (cy),
    .sum   (fa_s),
    .carry (fa_c)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && start_in;
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
  assign r_cat  = {fa_s, r_sr};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_in) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sr <= a_in;
      b_sr <= b_in;
      r_sr <= '0;
      cnt  <= '0;
      cy   <= c_in;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_cat[WIDTH-1:1];
      cnt  <= cnt + CW'(1);
      cy   <= fa_c;
      if (last) begin
        sum_out   <= r_cat;
        carry_out <= fa_c;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of serial_add_ctrl, WIDTH=8.
// Expected values are hand-computed constants.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         c     = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .start_in  (start),
    .a_in      (a),
    .b_in      (b),
    .c_in      (c),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum),
    .carry_out (carry)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One addition; operands are scrambled right after the accept edge.
  task automatic op(input logic [W-1:0] av,
                    input logic [W-1:0] bv,
                    input logic         cv,
                    input string        tag,
                    input logic [W-1:0] es,
                    input logic         ec);
    int nbusy;
    int ndone;
    int dedge;
    logic [W-1:0] prev;
    prev = sum;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; c = cv;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; c = ~cv;
    nbusy = 0; ndone = 0; dedge = -1;
    for (int i = 0; i < W + 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (dedge < 0) dedge = i;
      end
      if (i == W - 1) chk({tag, " hold"}, 32'(sum), 32'(prev));
    end
    chk({tag, " busy_cyc"}, nbusy, W + 1);
    chk({tag, " done_cnt"}, ndone, 1);
    chk({tag, " done_edge"}, dedge, W);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " carry"}, 32'(carry), 32'(ec));
  endtask

  initial begin
    int nd;
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    #1 rst_n = 1'b1;
    #1;
    chk("rel busy", 32'(busy), 0);
    chk("rel done", 32'(done), 0);
    chk("rel sum", 32'(sum), 0);
    chk("rel carry", 32'(carry), 0);

    op(8'h05, 8'h03, 1'b0, "05+03", 8'h08, 1'b0);
    op(8'hFF, 8'h01, 1'b0, "FF+01", 8'h00, 1'b1);
    op(8'hFF, 8'hFF, 1'b1, "FF+FF+1", 8'hFF, 1'b1);

    // start held high: back-to-back, operands change mid-run
    @(negedge clk);
    start = 1'b1; a = 8'h0A; b = 8'h14; c = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44; c = 1'b0;
    for (int i = 1; i <= 2 * W + 2; i++) begin
      @(posedge clk); #1;
      if (i == W) begin
        chk("b2b done1", 32'(done), 1);
        chk("b2b sum1", 32'(sum), 32'h1F);
        chk("b2b carry1", 32'(carry), 0);
      end
      if (i == W + 1) begin
        chk("b2b idle busy", 32'(busy), 0);
        chk("b2b idle done", 32'(done), 0);
      end
      if (i == W + 2) begin
        chk("b2b reaccept", 32'(busy), 1);
        start = 1'b0;
      end
      if (i == 2 * W + 2) begin
        chk("b2b done2", 32'(done), 1);
        chk("b2b sum2", 32'(sum), 32'h77);
        chk("b2b carry2", 32'(carry), 0);
      end
    end
    repeat (2) @(posedge clk);

    // reset mid-run
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; c = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort sum", 32'(sum), 0);
    chk("abort carry", 32'(carry), 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort no_done", nd, 0);
    @(negedge clk) rst_n = 1'b1;
    op(8'h01, 8'h01, 1'b0, "post_rst 01+01", 8'h02, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
